// File: rtl/vec_loader_if.sv
// Byte-stream input and vector-output handshake bundle for vec_loader.
// The master side is the byte source plus the transform-stage consumer; the slave side is the loader.
interface vec_loader_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [19:0]      vec;
  logic             vec_valid;
  logic             vec_ready;
  logic [CNT_W-1:0] vec_count;
  logic             pad_err;

  modport master (
    output in_data, in_valid, flush, vec_ready,
    input  in_ready, vec, vec_valid, vec_count, pad_err
  );

  modport slave (
    input  in_data, in_valid, flush, vec_ready,
    output in_ready, vec, vec_valid, vec_count, pad_err
  );
endinterface

// File: rtl/vec_loader.sv
// Packs a little-endian byte stream, three bytes at a time, into 20-bit vectors and queues them in a small FIFO.
// Optional VEC_LOADER_PAD_CHECK_EN: drop vectors whose third byte has nonzero bits [7:4] and pulse pad_err.
//
// state | meaning
// S_B0  | waiting for byte 0 (vec[7:0])
// S_B1  | waiting for byte 1 (vec[15:8])
// S_B2  | waiting for byte 2 (vec[19:16]); completes the vector
module vec_loader #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  vec_loader_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_B0 = 2'd0,
    S_B1 = 2'd1,
    S_B2 = 2'd2
  } bcnt_e;

  bcnt_e            bcnt_q, bcnt_d;
  logic [15:0]      part_q, part_d;
  logic [19:0]      mem_q [DEPTH];
  logic [19:0]      mem_d [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pad_err_q, pad_err_d;

  logic full;
  logic in_ready;
  logic acc;
  logic done;
  logic pad_bad;
  logic push;
  logic pop;

  assign full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

`ifdef VEC_LOADER_PAD_CHECK_EN
  assign pad_bad = |bus.in_data[7:4];
`else
  logic unused_pad_bits;
  assign unused_pad_bits = ^bus.in_data[7:4];
  assign pad_bad = 1'b0;
`endif

  assign acc  = bus.in_valid && in_ready;
  assign done = acc && (bcnt_q == S_B2);
  assign push = done && !pad_bad;
  assign pop  = valid_q && bus.vec_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q <= S_B0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end

  always_comb begin
    bcnt_d = bcnt_q;
    if (bus.flush) begin
      bcnt_d = S_B0;
    end else if (acc) begin
      case (bcnt_q)
        S_B0:    bcnt_d = S_B1;
        S_B1:    bcnt_d = S_B2;
        default: bcnt_d = S_B0;
      endcase
    end
  end

  // Only the final byte can stall: bytes 0 and 1 land in the partial register, not the FIFO.
  always_comb begin
    in_ready = !bus.flush && !((bcnt_q == S_B2) && full);
  end

  always_comb begin
    part_d    = part_q;
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    pad_err_d = done && pad_bad;

    if (bus.flush) begin
      part_d = '0;
    end else if (acc) begin
      case (bcnt_q)
        S_B0:    part_d[7:0]  = bus.in_data;
        S_B1:    part_d[15:8] = bus.in_data;
        default: part_d       = '0;
      endcase
    end

    if (push) begin
      mem_d[wptr_q[AW-1:0]] = {bus.in_data[3:0], part_q};
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
      cnt_d  = cnt_q + CNT_ONE;
    end
    valid_d = (wptr_d != rptr_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      part_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      pad_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      part_q    <= part_d;
      mem_q     <= mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      pad_err_q <= pad_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.vec       = mem_q[rptr_q[AW-1:0]];
  assign bus.vec_valid = valid_q;
  assign bus.vec_count = cnt_q;
  assign bus.pad_err   = pad_err_q;
endmodule

// File: tb/tb_vec_loader.sv
// Directed bench for vec_loader: vector table, back-pressure, flush, pad check, mid-run reset, long random-ready stream.
module tb_vec_loader;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vec_loader_if #(.CNT_W(CNT_W)) bus ();

  vec_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CNT_W-1:0] cnt_model = '0;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [19:0] exp_vec;
    logic        exp_valid;
    logic        exp_pad;
  } vec_t;

  vec_t tbl[6];
  logic [19:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_byte_timeout: byte %0h in_ready got 0 expected 1", b);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  initial begin
    tbl[0] = '{8'h34, 8'h12, 8'h05, 20'h51234, 1'b1, 1'b0};
    tbl[1] = '{8'hFF, 8'hFF, 8'h0F, 20'hFFFFF, 1'b1, 1'b0};
    tbl[2] = '{8'h01, 8'h02, 8'h03, 20'h30201, 1'b1, 1'b0};
`ifdef VEC_LOADER_PAD_CHECK_EN
    tbl[3] = '{8'h00, 8'h00, 8'hF7, 20'h00000, 1'b0, 1'b1};
    tbl[4] = '{8'hAB, 8'hCD, 8'h1E, 20'h00000, 1'b0, 1'b1};
`else
    tbl[3] = '{8'h00, 8'h00, 8'hF7, 20'h70000, 1'b1, 1'b0};
    tbl[4] = '{8'hAB, 8'hCD, 8'h1E, 20'hECDAB, 1'b1, 1'b0};
`endif
    tbl[5] = '{8'h00, 8'h00, 8'h00, 20'h00000, 1'b1, 1'b0};

    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.vec_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_vec_valid", 32'(bus.vec_valid), 0);
    chk("reset_vec",       32'(bus.vec), 0);
    chk("reset_in_ready",  32'(bus.in_ready), 1);
    chk("reset_vec_count", 32'(bus.vec_count), 0);
    chk("reset_pad_err",   32'(bus.pad_err), 0);

    // Table vectors with consumer always ready: one-cycle valid, then popped.
    @(negedge clk);
    bus.vec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_vec(tbl[i].b0, tbl[i].b1, tbl[i].b2);
      chk($sformatf("tbl%0d_valid", i), 32'(bus.vec_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_pad", i),   32'(bus.pad_err),   32'(tbl[i].exp_pad));
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_vec", i), 32'(bus.vec), 32'(tbl[i].exp_vec));
        cnt_model = cnt_model + 1'b1;
      end
      @(negedge clk);
      chk($sformatf("tbl%0d_valid_after", i), 32'(bus.vec_valid), 0);
      chk($sformatf("tbl%0d_pad_after", i),   32'(bus.pad_err), 0);
      chk($sformatf("tbl%0d_count", i),       32'(bus.vec_count), 32'(cnt_model));
    end

    // Back-pressure: A, B fill the FIFO; C's third byte stalls until one pop.
    bus.vec_ready = 1'b0;
    send_vec(8'h11, 8'h22, 8'h03);
    send_vec(8'h44, 8'h55, 8'h06);
    send_byte(8'h77);
    send_byte(8'h88);
    bus.in_data  = 8'h09;
    bus.in_valid = 1'b1;
    #1;
    chk("bp_in_ready_stall", 32'(bus.in_ready), 0);
    chk("bp_head_a",         32'(bus.vec), 32'h32211);
    @(negedge clk);
    #1;
    chk("bp_in_ready_stall2", 32'(bus.in_ready), 0);
    chk("bp_head_a_stable",   32'(bus.vec), 32'h32211);
    bus.vec_ready = 1'b1;
    #1;
    chk("bp_in_ready_no_comb", 32'(bus.in_ready), 0);
    @(negedge clk);
    bus.vec_ready = 1'b0;
    cnt_model = cnt_model + 1'b1;
    #1;
    chk("bp_in_ready_rise", 32'(bus.in_ready), 1);
    chk("bp_head_b",        32'(bus.vec), 32'h65544);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_head_b_hold", 32'(bus.vec), 32'h65544);
    bus.vec_ready = 1'b1;
    @(negedge clk);
    chk("bp_head_c",  32'(bus.vec), 32'h98877);
    chk("bp_valid_c", 32'(bus.vec_valid), 1);
    @(negedge clk);
    cnt_model = cnt_model + 2'd2;
    chk("bp_drained", 32'(bus.vec_valid), 0);
    chk("bp_count",   32'(bus.vec_count), 32'(cnt_model));

    // Flush drops the partial bytes and refuses the coincident byte.
    send_byte(8'hAA);
    send_byte(8'hBB);
    bus.in_data  = 8'hCC;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    #1;
    chk("flush_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_no_push", 32'(bus.vec_valid), 0);
    send_vec(8'h01, 8'h02, 8'h03);
    chk("flush_vec",   32'(bus.vec), 32'h30201);
    chk("flush_valid", 32'(bus.vec_valid), 1);
    @(negedge clk);
    cnt_model = cnt_model + 1'b1;
    chk("flush_count", 32'(bus.vec_count), 32'(cnt_model));

    // Reset with two queued vectors and a partial byte pending.
    bus.vec_ready = 1'b0;
    send_vec(8'h12, 8'h34, 8'h05);
    send_vec(8'h67, 8'h89, 8'h0A);
    send_byte(8'hEE);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(bus.vec_valid), 0);
    chk("rst_mid_count", 32'(bus.vec_count), 0);
    chk("rst_mid_vec",   32'(bus.vec), 0);
    @(negedge clk);
    rst = 1'b0;
    cnt_model = '0;
    bus.vec_ready = 1'b1;
    send_vec(8'h21, 8'h43, 8'h05);
    chk("rst_new_vec",   32'(bus.vec), 32'h54321);
    chk("rst_new_valid", 32'(bus.vec_valid), 1);
    @(negedge clk);
    cnt_model = cnt_model + 1'b1;
    chk("rst_new_single", 32'(bus.vec_valid), 0);
    chk("rst_new_count",  32'(bus.vec_count), 32'(cnt_model));

    // Long stream, pseudo-random consumer readiness; counter wraps at 8 bits.
    begin
      int got = 0;
      fork
        begin
          for (int k = 0; k < 300; k++) begin
            logic [7:0] b0, b1, b2;
            logic [31:0] r;
            r  = $urandom_range(0, 15);
            b0 = 8'(k) ^ 8'h5A;
            b1 = 8'(k * 13);
            b2 = {4'h0, r[3:0]};
            exp_q.push_back({b2[3:0], b1, b0});
            send_vec(b0, b1, b2);
          end
        end
        begin
          int cyc = 0;
          while (got < 300 && cyc < 20000) begin
            logic r;
            @(negedge clk);
            r = 1'($urandom_range(0, 1));
            bus.vec_ready = r;
            if (bus.vec_valid && r) begin
              if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stream_extra: got %0h expected none", bus.vec);
              end else begin
                chk($sformatf("stream_vec%0d", got), 32'(bus.vec), 32'(exp_q.pop_front()));
              end
              got++;
              cnt_model = cnt_model + 1'b1;
            end
            cyc++;
          end
        end
      join
      @(negedge clk);
      bus.vec_ready = 1'b0;
      chk("stream_received", 32'(got), 300);
      chk("stream_count",    32'(bus.vec_count), 32'(cnt_model));
      chk("stream_empty",    32'(bus.vec_valid), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vec_loader.md
# vec_loader

Upstream feeder for the 20-bit combinational transform stage (20-bit vector in, 10-bit result out). It accepts a byte stream over a valid/ready handshake and assembles every three bytes into one 20-bit vector. Completed vectors are buffered in a small FIFO and presented to the transform stage with their own valid/ready handshake. The block replaces file-loaded stimulus with a streaming source in hardware-level tests.

## Interface
Parameters:
- DEPTH, 2, vector FIFO depth; power of two, minimum 2
- CNT_W, 16, width of the delivered-vector counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- in_data  input  8  byte from the source
- in_valid  input  1  in_data valid
- in_ready  output  1  byte accepted when in_valid && in_ready at a clk edge
- flush  input  1  synchronous; discards any partially assembled vector
- vec  output  20  head-of-FIFO vector to the transform stage
- vec_valid  output  1  FIFO non-empty
- vec_ready  input  1  consumer accepts vec when vec_valid && vec_ready
- vec_count  output  CNT_W  count of vectors popped since reset
- pad_err  output  1  one-cycle pulse on a rejected vector (see Configuration)

## Operation
- Assembly order is little-endian:
  - byte 0 -> vec[7:0]
  - byte 1 -> vec[15:8]
  - byte 2 bits [3:0] -> vec[19:16]
- Byte counter bcnt takes the values 0, 1, 2 and advances on each accepted byte. Accepting the byte at bcnt==2 completes the vector, pushes it into the FIFO and returns bcnt to 0.
- in_ready = !flush && !(bcnt==2 && fifo_full).
  - Bytes 0 and 1 are always accepted, even when the FIFO is full.
  - in_ready has no combinational dependence on vec_ready.
- FIFO: DEPTH entries, read and write pointers with an extra wrap bit.
  - full = pointers differ only in the wrap bit; empty = pointers equal.
  - Push and pop in the same cycle are both performed, and occupancy is unchanged.
- vec is driven from the head entry and is stable while vec_valid && !vec_ready.
- vec_count increments on each pop and wraps modulo 2^CNT_W.
- flush: bcnt <- 0 and the partial bytes are dropped. A byte presented in the same cycle is not accepted (in_ready=0). FIFO contents and vec_count are unaffected.
- Reset values: bcnt=0, FIFO empty, vec_valid=0, in_ready=1 (when flush=0), vec=0, vec_count=0, pad_err=0. The partial-assembly register clears to 0.
- Reset asserted mid-operation immediately empties the FIFO and discards the partial vector. No vector survives reset.

## Timing
- Latency: third byte accepted at edge N -> vec_valid=1 and vec holds the vector during cycle N+1.
- Throughput: one byte per cycle; one vector per 3 cycles sustained with vec_ready held high.
- A pop at edge M updates vec to the next entry, or deasserts vec_valid, in cycle M+1.
- Back-pressure: with the FIFO full and vec_ready=0, the third byte is stalled (in_ready=0) until a pop frees a slot. in_ready rises in the cycle after that pop edge.
- pad_err is registered: high for exactly cycle N+1 after the offending byte is accepted at edge N.
- All outputs are registered except in_ready, which is a function of registered state and the flush input, and vec, which is a FIFO read mux on registered pointers.

## Configuration
- VEC_LOADER_PAD_CHECK_EN defined:
  - If byte 2 bits [7:4] are nonzero, the byte is still accepted and bcnt returns to 0, but the vector is not pushed and pad_err pulses.
  - vec_count does not count rejected vectors.
- VEC_LOADER_PAD_CHECK_EN undefined:
  - Byte 2 bits [7:4] are ignored and every completed vector is pushed.
  - pad_err is tied to 0.

## Test plan
- Reset, then bytes 0x34, 0x12, 0x05 with vec_ready=1 -> vec=20'h51234, vec_valid high for exactly one cycle, then vec_count=1.
- vec_ready=0, DEPTH=2, nine bytes forming vectors A, B, C -> in_ready=0 on C's third byte. Raise vec_ready for one cycle -> A popped; in_ready rises the next cycle; C is accepted. Order is A, B, C.
- Bytes 0xAA, 0xBB, then flush=1 together with byte 0xCC -> 0xCC not accepted. Follow with 0x01, 0x02, 0x03 -> vec=20'h30201.
- Byte 2 = 0xF7 in the pattern 0x00, 0x00, 0xF7. With the macro defined -> pad_err pulses, no push, vec_count unchanged. Without the macro -> vec=20'h70000.
- Assert rst while two vectors are queued and bcnt=1 -> vec_valid=0 and vec_count=0 asynchronously. Then 3 new bytes -> a single correct vector appears.
- Continuous stream of 300 vectors with vec_ready toggling pseudo-randomly -> no loss or reordering, and vec_count wraps correctly with CNT_W=8.
